// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - stepper move encodings, FSM states and coil phase table
// Shared with the PMOD top level.
package stepper_pkg;

  typedef enum logic [1:0] {
    MODE_WAVE     = 2'b00,
    MODE_FULL     = 2'b01,
    MODE_HALF     = 2'b10,
    MODE_HALF_ALT = 2'b11
  } step_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } step_state_t;

  // Coil patterns {A,B,C,D}, entry 0 in the low nibble.
  localparam logic [31:0] PHASE_TABLE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  function automatic logic [3:0] phase_coil(input logic [2:0] idx);
    return PHASE_TABLE[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/step_edge_sync.sv
// rtl/step_edge_sync.sv - synchronises the divided step clock, flags its rising edges
module step_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic step_in,
  output logic step_ev
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= step_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign step_ev = s2 & ~s3;

endmodule

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - executes one stepper move command at a time on the PMOD coils
module step_sequencer
  import stepper_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int POS_W       = 16,
  parameter bit HOLD_TORQUE = 1'b1
) (
  input  logic             n_CLK,
  input  logic             n_RST,
  input  logic             i_STEP_CLK,
  input  logic             i_CMD_VALID,
  output logic             o_CMD_READY,
  input  logic             i_CMD_DIR,
  input  logic [1:0]       i_CMD_MODE,
  input  logic [CNT_W-1:0] i_CMD_STEPS,
  input  logic             i_ABORT,
  output logic [3:0]       o_COIL,
  output logic             o_BUSY,
  output logic             o_DONE,
  output logic             o_ABORTED,
  output logic [POS_W-1:0] o_POS
);

  logic step_ev;

  step_edge_sync u_edge_sync (
    .clk     (n_CLK),
    .rst     (n_RST),
    .step_in (i_STEP_CLK),
    .step_ev (step_ev)
  );

  step_state_t      state, state_nxt;
  logic [2:0]       idx;
  logic [POS_W-1:0] pos;
  logic [CNT_W-1:0] remaining;
  logic             dir, half, aborted, energised;
  logic             accept, abort_run, step_run;
  logic [2:0]       stride;

  assign accept    = (state == ST_IDLE) && i_CMD_VALID;
  assign abort_run = (state == ST_RUN) && i_ABORT;
  // Abort beats a coincident step edge: the step is simply not taken.
  assign step_run  = (state == ST_RUN) && step_ev && !i_ABORT;
  assign stride    = half ? 3'd1 : 3'd2;

  always_ff @(posedge n_CLK) begin
    if (n_RST) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (i_CMD_VALID) state_nxt = (i_CMD_STEPS == '0) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (i_ABORT)                                  state_nxt = ST_DONE;
        else if (step_ev && remaining == CNT_W'(1))   state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge n_CLK) begin
    if (n_RST) begin
      idx       <= 3'd0;
      pos       <= '0;
      remaining <= '0;
      dir       <= 1'b0;
      half      <= 1'b0;
      aborted   <= 1'b0;
      energised <= 1'b0;
    end else begin
      if (accept) begin
        dir       <= i_CMD_DIR;
        half      <= i_CMD_MODE[1];
        remaining <= i_CMD_STEPS;
        aborted   <= 1'b0;
        energised <= 1'b1;
        // Align the phase index to the mode's lattice; not counted as a step.
        case (step_mode_t'(i_CMD_MODE))
          MODE_WAVE: idx <= {idx[2:1], 1'b0};
          MODE_FULL: idx <= {idx[2:1], 1'b1};
          default:   idx <= idx;
        endcase
      end
      if (abort_run) aborted <= 1'b1;
      if (step_run) begin
        idx       <= dir ? idx + stride : idx - stride;
        pos       <= dir ? pos + POS_W'(1) : pos - POS_W'(1);
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

  // Coils stay dark after reset until the first move, even with holding torque.
  assign o_COIL      = ((state == ST_RUN) || (HOLD_TORQUE && energised)) ? phase_coil(idx) : 4'b0000;
  assign o_CMD_READY = (state == ST_IDLE);
  assign o_BUSY      = (state == ST_RUN);
  assign o_DONE      = (state == ST_DONE);
  assign o_ABORTED   = aborted;
  assign o_POS       = pos;

endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - scoreboard bench for step_sequencer
module tb_step_sequencer;

  logic        n_CLK = 1'b0;
  logic        n_RST = 1'b1;
  logic        i_STEP_CLK = 1'b0;
  logic        i_CMD_VALID = 1'b0;
  logic        i_CMD_DIR = 1'b0;
  logic [1:0]  i_CMD_MODE = 2'b00;
  logic [15:0] i_CMD_STEPS = 16'd0;
  logic        i_ABORT = 1'b0;

  logic        o_CMD_READY, o_BUSY, o_DONE, o_ABORTED;
  logic [3:0]  o_COIL;
  logic [15:0] o_POS;
  logic        nh_ready, nh_busy, nh_done, nh_aborted;
  logic [3:0]  nh_coil;
  logic [15:0] nh_pos;

  step_sequencer #(.CNT_W(16), .POS_W(16), .HOLD_TORQUE(1'b1)) dut (
    .n_CLK(n_CLK), .n_RST(n_RST), .i_STEP_CLK(i_STEP_CLK),
    .i_CMD_VALID(i_CMD_VALID), .o_CMD_READY(o_CMD_READY), .i_CMD_DIR(i_CMD_DIR),
    .i_CMD_MODE(i_CMD_MODE), .i_CMD_STEPS(i_CMD_STEPS), .i_ABORT(i_ABORT),
    .o_COIL(o_COIL), .o_BUSY(o_BUSY), .o_DONE(o_DONE), .o_ABORTED(o_ABORTED), .o_POS(o_POS)
  );

  step_sequencer #(.CNT_W(16), .POS_W(16), .HOLD_TORQUE(1'b0)) dut_nh (
    .n_CLK(n_CLK), .n_RST(n_RST), .i_STEP_CLK(i_STEP_CLK),
    .i_CMD_VALID(i_CMD_VALID), .o_CMD_READY(nh_ready), .i_CMD_DIR(i_CMD_DIR),
    .i_CMD_MODE(i_CMD_MODE), .i_CMD_STEPS(i_CMD_STEPS), .i_ABORT(i_ABORT),
    .o_COIL(nh_coil), .o_BUSY(nh_busy), .o_DONE(nh_done), .o_ABORTED(nh_aborted), .o_POS(nh_pos)
  );

  always #21 n_CLK = ~n_CLK;

  typedef struct packed {
    logic [3:0]  coil;
    logic [15:0] pos;
  } step_exp_t;

  int          checks = 0;
  int          errors = 0;
  step_exp_t   exp_q[$];
  bit          done_q[$];
  logic [3:0]  tab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
  int          model_idx = 0;
  logic [15:0] model_pos = 16'd0;
  bit          cur_dir, cur_half;
  bit          mon_en = 1'b0;
  logic [15:0] last_pos = 16'd0;

  // Step and done monitor: every position change and every o_DONE pulse must be expected.
  always @(negedge n_CLK) begin
    step_exp_t e;
    bit        ab;
    if (!mon_en) begin
      last_pos = o_POS;
    end else begin
      if (o_POS !== last_pos) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_step got coil=%b pos=%h", o_COIL, o_POS);
        end else begin
          e = exp_q.pop_front();
          if ({o_COIL, o_POS} !== e) begin
            errors++;
            $display("FAIL step got coil=%b pos=%h exp coil=%b pos=%h", o_COIL, o_POS, e.coil, e.pos);
          end
        end
        last_pos = o_POS;
      end
      if (o_DONE === 1'b1) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done got aborted=%b", o_ABORTED);
        end else begin
          ab = done_q.pop_front();
          if (o_ABORTED !== ab) begin
            errors++;
            $display("FAIL done_aborted got %b exp %b", o_ABORTED, ab);
          end
        end
      end
    end
  end

  task automatic do_reset();
    mon_en = 1'b0;
    @(posedge n_CLK); #1;
    n_RST = 1'b1; i_STEP_CLK = 1'b0; i_ABORT = 1'b0; i_CMD_VALID = 1'b0;
    @(posedge n_CLK); #1;
    n_RST = 1'b0;
    model_idx = 0; model_pos = 16'd0;
    exp_q.delete(); done_q.delete();
    @(negedge n_CLK); #1;
    mon_en = 1'b1;
  endtask

  task automatic send_cmd(input bit dir, input logic [1:0] mode, input logic [15:0] steps);
    @(posedge n_CLK); #1;
    i_CMD_VALID = 1'b1; i_CMD_DIR = dir; i_CMD_MODE = mode; i_CMD_STEPS = steps;
    cur_dir = dir; cur_half = mode[1];
    if (mode == 2'b00) model_idx = model_idx & 6;
    if (mode == 2'b01) model_idx = model_idx | 1;
    @(posedge n_CLK); #1;
    i_CMD_VALID = 1'b0;
  endtask

  task automatic model_step();
    int d;
    d = cur_half ? 1 : 2;
    model_idx = cur_dir ? (model_idx + d) % 8 : (model_idx + 8 - d) % 8;
    model_pos = cur_dir ? model_pos + 16'd1 : model_pos - 16'd1;
    exp_q.push_back(step_exp_t'({tab[model_idx], model_pos}));
  endtask

  task automatic step_pulse(input int hi, input int lo, input bit expect_step);
    if (expect_step) model_step();
    i_STEP_CLK = 1'b1;
    repeat (hi) @(posedge n_CLK);
    #1 i_STEP_CLK = 1'b0;
    repeat (lo) @(posedge n_CLK);
    #1;
  endtask

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge n_CLK);
      if (o_CMD_READY === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_COIL !== 4'b0000) begin errors++; $display("FAIL reset_coil got %b exp 0000", o_COIL); end
    checks++; if (o_POS !== 16'd0) begin errors++; $display("FAIL reset_pos got %h exp 0000", o_POS); end
    checks++; if ({o_BUSY, o_DONE, o_ABORTED} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {o_BUSY, o_DONE, o_ABORTED}); end
    checks++; if (o_CMD_READY !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_CMD_READY); end
  endtask

  task automatic test_half_fwd();
    bit ok;
    done_q.push_back(1'b0);
    send_cmd(1'b1, 2'b10, 16'd3);
    @(negedge n_CLK);
    checks++; if (o_BUSY !== 1'b1 || o_COIL !== 4'b1000) begin errors++; $display("FAIL half_align got busy=%b coil=%b exp 1 1000", o_BUSY, o_COIL); end
    checks++; if (nh_coil !== 4'b1000) begin errors++; $display("FAIL half_nh_run_coil got %b exp 1000", nh_coil); end
    @(posedge n_CLK); #1;
    for (int i = 0; i < 3; i++) step_pulse(12, 12, 1'b1);
    wait_ready(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL half_timeout got busy exp ready"); end
    checks++; if (o_POS !== 16'd3 || o_COIL !== 4'b0110) begin errors++; $display("FAIL half_end got pos=%h coil=%b exp 0003 0110", o_POS, o_COIL); end
    checks++; if (nh_coil !== 4'b0000 || nh_pos !== 16'd3) begin errors++; $display("FAIL half_nh_idle got coil=%b pos=%h exp 0000 0003", nh_coil, nh_pos); end
    checks++; if (o_ABORTED !== 1'b0) begin errors++; $display("FAIL half_aborted got %b exp 0", o_ABORTED); end
  endtask

  task automatic test_full_rev();
    bit ok;
    do_reset();
    done_q.push_back(1'b0);
    send_cmd(1'b0, 2'b01, 16'd2);
    @(negedge n_CLK);
    checks++; if (o_COIL !== 4'b1100 || o_POS !== 16'd0) begin errors++; $display("FAIL full_align got coil=%b pos=%h exp 1100 0000", o_COIL, o_POS); end
    @(posedge n_CLK); #1;
    for (int i = 0; i < 2; i++) step_pulse(12, 12, 1'b1);
    wait_ready(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_timeout got busy exp ready"); end
    checks++; if (o_POS !== 16'hFFFE || o_COIL !== 4'b0011) begin errors++; $display("FAIL full_end got pos=%h coil=%b exp fffe 0011", o_POS, o_COIL); end
  endtask

  task automatic test_zero_steps();
    done_q.push_back(1'b0);
    send_cmd(1'b1, 2'b00, 16'd0);
    @(negedge n_CLK);
    checks++; if (o_DONE !== 1'b1) begin errors++; $display("FAIL zero_done got %b exp 1", o_DONE); end
    checks++; if (o_COIL !== 4'b0010 || o_POS !== 16'hFFFE) begin errors++; $display("FAIL zero_align got coil=%b pos=%h exp 0010 fffe", o_COIL, o_POS); end
    @(negedge n_CLK);
    checks++; if (o_DONE !== 1'b0 || o_CMD_READY !== 1'b1) begin errors++; $display("FAIL zero_after got done=%b ready=%b exp 0 1", o_DONE, o_CMD_READY); end
  endtask

  task automatic test_abort();
    send_cmd(1'b1, 2'b10, 16'd10);
    for (int i = 0; i < 3; i++) step_pulse(12, 12, 1'b1);
    // Rise now, step_ev appears after two edges; abort is raised to meet it.
    i_STEP_CLK = 1'b1;
    @(posedge n_CLK);
    @(posedge n_CLK); #1;
    i_ABORT = 1'b1;
    done_q.push_back(1'b1);
    @(posedge n_CLK); #1;
    i_ABORT = 1'b0;
    @(negedge n_CLK);
    checks++; if (o_DONE !== 1'b1 || o_ABORTED !== 1'b1) begin errors++; $display("FAIL abort_done got done=%b aborted=%b exp 1 1", o_DONE, o_ABORTED); end
    checks++; if (o_POS !== 16'h0001) begin errors++; $display("FAIL abort_pos got %h exp 0001", o_POS); end
    repeat (5) @(posedge n_CLK);
    #1 i_STEP_CLK = 1'b0;
    for (int i = 0; i < 2; i++) step_pulse(6, 6, 1'b0);
    checks++; if (o_ABORTED !== 1'b1 || o_POS !== 16'h0001) begin errors++; $display("FAIL abort_hold got aborted=%b pos=%h exp 1 0001", o_ABORTED, o_POS); end
  endtask

  task automatic test_wrap_busy();
    bit ok;
    logic [15:0] n;
    n = 16'h7FFF - model_pos;
    done_q.push_back(1'b0);
    send_cmd(1'b1, 2'b11, n);
    checks++; if (o_ABORTED !== 1'b0) begin errors++; $display("FAIL accept_clears_aborted got %b exp 0", o_ABORTED); end
    for (int i = 0; i < int'(n); i++) begin
      if (i == 0) begin i_CMD_VALID = 1'b1; i_CMD_DIR = 1'b0; i_CMD_MODE = 2'b00; i_CMD_STEPS = 16'd5; end
      if (i == 50) i_CMD_VALID = 1'b0;
      if (i == 20) begin
        checks++; if (o_CMD_READY !== 1'b0 || o_BUSY !== 1'b1) begin errors++; $display("FAIL busy_not_ready got ready=%b busy=%b exp 0 1", o_CMD_READY, o_BUSY); end
      end
      step_pulse(1, 1, 1'b1);
    end
    wait_ready(100, ok);
    checks++; if (!ok || o_POS !== 16'h7FFF) begin errors++; $display("FAIL wrap_reach got ok=%b pos=%h exp 1 7fff", ok, o_POS); end
    done_q.push_back(1'b0);
    send_cmd(1'b1, 2'b10, 16'd1);
    step_pulse(4, 4, 1'b1);
    wait_ready(100, ok);
    checks++; if (!ok || o_POS !== 16'h8000) begin errors++; $display("FAIL wrap_pos got ok=%b pos=%h exp 1 8000", ok, o_POS); end
  endtask

  task automatic test_reset_mid_run();
    send_cmd(1'b1, 2'b10, 16'd5);
    for (int i = 0; i < 2; i++) step_pulse(12, 12, 1'b1);
    checks++; if (o_BUSY !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b exp 1", o_BUSY); end
    mon_en = 1'b0;
    n_RST = 1'b1;
    @(posedge n_CLK); #1;
    n_RST = 1'b0;
    @(negedge n_CLK);
    checks++; if (o_COIL !== 4'b0000 || o_POS !== 16'd0) begin errors++; $display("FAIL midrun_reset got coil=%b pos=%h exp 0000 0000", o_COIL, o_POS); end
    checks++; if (o_BUSY !== 1'b0 || o_DONE !== 1'b0) begin errors++; $display("FAIL midrun_flags got busy=%b done=%b exp 0 0", o_BUSY, o_DONE); end
    model_idx = 0; model_pos = 16'd0;
    #1 mon_en = 1'b1;
    @(posedge n_CLK); #1;
    step_pulse(6, 6, 1'b0);
    checks++; if (o_POS !== 16'd0 || o_CMD_READY !== 1'b1) begin errors++; $display("FAIL midrun_idle got pos=%h ready=%b exp 0000 1", o_POS, o_CMD_READY); end
  endtask

  initial begin
    test_reset();
    test_half_fwd();
    test_full_rev();
    test_zero_steps();
    test_abort();
    test_wrap_busy();
    test_reset_mid_run();
    repeat (4) @(negedge n_CLK);
    checks++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got steps=%0d dones=%0d exp 0 0", exp_q.size(), done_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
